// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: valid/ready command sequencer driving the write/read pins of a small register file.
// Define REGFILE_CTRL_VERIFY_EN to add write-verify readback (VREAD/VCHECK states and err_count).
module regfile_access_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [DATA_W-1:0] rf_data_in,
    output logic [ADDR_W-1:0] rf_write_add,
    output logic [ADDR_W-1:0] rf_read_add,
    output logic              rf_write_en,
    output logic              rf_read_en,
    input  logic [DATA_W-1:0] rf_data_out
`ifdef REGFILE_CTRL_VERIFY_EN
    ,
    output logic [7:0]        err_count
`endif
);

`ifdef REGFILE_CTRL_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        VREAD   = 3'd4,
        VCHECK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3
    } state_t;
`endif

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;

    assign accept = cmd_valid && cmd_ready;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The command direction is remembered by the WRITE/READ branch taken here.
    // NOTE: the default assignment at the top of a combinational block keeps
    // every path assigned, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cmd_write ? WRITE : READ;
                end
            end
`ifdef REGFILE_CTRL_VERIFY_EN
            WRITE:   state_d = VREAD;
            VREAD:   state_d = VCHECK;
            VCHECK:  state_d = IDLE;
`else
            WRITE:   state_d = IDLE;
`endif
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore decodes only: the file pins never depend on the command inputs.
    always_comb begin
        cmd_ready   = (state_q == IDLE) && !rst;
        busy        = (state_q != IDLE);
        rf_write_en = (state_q == WRITE);
        rf_read_en  = 1'b0;
        unique case (state_q)
            READ, CAPTURE: rf_read_en = 1'b1;
`ifdef REGFILE_CTRL_VERIFY_EN
            VREAD, VCHECK: rf_read_en = 1'b1;
`endif
            default:       rf_read_en = 1'b0;
        endcase
    end

    // Address and data pins move only on acceptance and hold in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr <= '0;
            lat_data <= '0;
        end else if (accept) begin
            lat_addr <= cmd_addr;
            lat_data <= cmd_data;
        end
    end

    assign rf_write_add = lat_addr;
    assign rf_read_add  = lat_addr;
    assign rf_data_in   = lat_data;

`ifdef REGFILE_CTRL_VERIFY_EN
    logic mismatch;
    logic rsp_err_q;

    assign mismatch = (rf_data_out != lat_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state_q == CAPTURE) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rf_data_out;
                rsp_err_q <= 1'b0;
            end else if (state_q == VCHECK) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rf_data_out;
                rsp_err_q <= mismatch;
            end
        end
    end

    assign rsp_err = rsp_err_q;

    // Saturating mismatch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if ((state_q == VCHECK) && mismatch && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state_q == CAPTURE) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rf_data_out;
            end
        end
    end

    assign rsp_err = 1'b0;
`endif

    // Enables come from disjoint state sets; this guards against future edits.
    assert property (@(posedge clk) disable iff (rst) !(rf_read_en && rf_write_en));

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: register-file model, table vectors,
// hand-written corner sequences and randomized commands against a memory-level model.
module tb_regfile_access_ctrl;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
`ifdef REGFILE_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [DATA_W-1:0] rf_data_in;
    logic [ADDR_W-1:0] rf_write_add;
    logic [ADDR_W-1:0] rf_read_add;
    logic              rf_write_en;
    logic              rf_read_en;
    logic [DATA_W-1:0] rf_data_out;
`ifdef REGFILE_CTRL_VERIFY_EN
    logic [7:0]        err_count;
`endif

    always #5 clk = ~clk;

    regfile_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .rf_data_in   (rf_data_in),
        .rf_write_add (rf_write_add),
        .rf_read_add  (rf_read_add),
        .rf_write_en  (rf_write_en),
        .rf_read_en   (rf_read_en),
        .rf_data_out  (rf_data_out)
`ifdef REGFILE_CTRL_VERIFY_EN
        ,
        .err_count    (err_count)
`endif
    );

    // Register file model: registered write, combinational read; optional stuck-at-0 on bit 0 of addr 1.
    logic [DATA_W-1:0] rf_mem [4];
    bit                fault_en = 1'b0;

    always @(posedge clk) begin
        if (rf_write_en) begin
            rf_mem[rf_write_add] <= (fault_en && rf_write_add == 2'd1) ? (rf_data_in & 4'b1110) : rf_data_in;
        end
    end
    assign rf_data_out = rf_mem[rf_read_add];

    // Protocol monitors.
    int   both_en_cycles = 0;
    int   rsp_stretch    = 0;
    logic rsp_prev       = 1'b0;
    always @(negedge clk) begin
        if (rf_read_en && rf_write_en) both_en_cycles <= both_en_cycles + 1;
        if (rsp_valid && rsp_prev) rsp_stretch <= rsp_stretch + 1;
        rsp_prev <= rsp_valid;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] ref_mem [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int guard = 0;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) check({name, "_ready_timeout"}, cmd_ready, 1);
    endtask

    // Issues one command and reports ready/response latency counted from the acceptance edge.
    task automatic run_cmd(input logic w, input logic [1:0] a, input logic [3:0] d,
                           output int rdy_lat, output int rsp_lat,
                           output logic [3:0] rd, output logic re);
        wait_ready("run_cmd");
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 2'($urandom);
        cmd_data  = 4'($urandom);
        rdy_lat = -1;
        rsp_lat = -1;
        rd = 'x;
        re = 'x;
        for (int c = 1; c <= 6 && rdy_lat < 0; c++) begin
            step();
            if (rsp_valid && rsp_lat < 0) begin
                rsp_lat = c;
                rd = rsp_data;
                re = rsp_err;
            end
            if (cmd_ready) rdy_lat = c;
        end
    endtask

    // Expectations from the timing rules: read ready/response at +2; write ready at +1
    // without response, or ready/response at +3 when verified.
    task automatic expect_cmd(input string name, input logic w, input logic [1:0] a,
                              input logic [3:0] d, input logic [3:0] exp_d);
        int rdy_lat, rsp_lat, exp_rdy, exp_rsp;
        logic [3:0] rd;
        logic re;
        exp_rdy = w ? (VERIFY ? 3 : 1) : 2;
        exp_rsp = w ? (VERIFY ? 3 : -1) : 2;
        run_cmd(w, a, d, rdy_lat, rsp_lat, rd, re);
        check({name, "_ready_lat"}, rdy_lat, exp_rdy);
        check({name, "_rsp_lat"}, rsp_lat, exp_rsp);
        if (exp_rsp > 0) begin
            check({name, "_rsp_data"}, rd, exp_d);
            check({name, "_rsp_err"}, re, 0);
        end
        if (w) ref_mem[a] = d;
    endtask

    typedef struct {
        logic       w;
        logic [1:0] a;
        logic [3:0] d;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[4];
        logic [3:0] rsp_q[$];
        logic [3:0] exp_q[$];
        vec_t b2b[4];
        int idx, cyc;
        bit acc;

        vecs[0]  = '{1'b1, 2'd0, 4'h5, 4'h5};
        vecs[1]  = '{1'b1, 2'd1, 4'h9, 4'h9};
        vecs[2]  = '{1'b1, 2'd2, 4'hC, 4'hC};
        vecs[3]  = '{1'b1, 2'd3, 4'h6, 4'h6};
        vecs[4]  = '{1'b0, 2'd0, 4'h0, 4'h5};
        vecs[5]  = '{1'b0, 2'd3, 4'hF, 4'h6};
        vecs[6]  = '{1'b0, 2'd1, 4'h3, 4'h9};
        vecs[7]  = '{1'b1, 2'd1, 4'h0, 4'h0};
        vecs[8]  = '{1'b0, 2'd1, 4'h7, 4'h0};
        vecs[9]  = '{1'b0, 2'd2, 4'h0, 4'hC};
        vecs[10] = '{1'b1, 2'd0, 4'hF, 4'hF};
        vecs[11] = '{1'b0, 2'd0, 4'h0, 4'hF};

        // Reset held with a pending command: nothing is accepted, all outputs at reset values.
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 2'd3;
        cmd_data  = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_rf_write_en", rf_write_en, 0);
            check("rst_rf_read_en", rf_read_en, 0);
            check("rst_rf_addrs", {rf_write_add, rf_read_add}, 0);
            check("rst_rf_data_in", rf_data_in, 0);
            check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        end
        cmd_valid = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);

        // Write 0001 to addr 3, then read it back with cycle-accurate checks.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 2'd3;
        cmd_data  = 4'b0001;
        step();
        cmd_valid = 1'b0;
        check("wr3_we_e0", rf_write_en, 1);
        check("wr3_add_e0", rf_write_add, 3);
        check("wr3_din_e0", rf_data_in, 4'b0001);
        check("wr3_re_e0", rf_read_en, 0);
        check("wr3_busy_e0", busy, 1);
        check("wr3_ready_e0", cmd_ready, 0);
        step();
        check("wr3_we_e1", rf_write_en, 0);
        check("wr3_ready_e1", cmd_ready, !VERIFY);
        wait_ready("wr3");
        ref_mem[3] = 4'b0001;

        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd3;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 2'd0;
        check("rd3_re_e0", rf_read_en, 1);
        check("rd3_radd_e0", rf_read_add, 3);
        check("rd3_rsp_e0", rsp_valid, 0);
        step();
        check("rd3_re_e1", rf_read_en, 1);
        check("rd3_radd_e1", rf_read_add, 3);
        check("rd3_rsp_e1", rsp_valid, 0);
        step();
        check("rd3_rsp_e2", rsp_valid, 1);
        check("rd3_data_e2", rsp_data, 4'b0001);
        check("rd3_ready_e2", cmd_ready, 1);
        check("rd3_re_e2", rf_read_en, 0);
        step();
        check("rd3_rsp_e3", rsp_valid, 0);
        check("rd3_hold_e3", rsp_data, 4'b0001);

        // Back-to-back with cmd_valid held high.
        b2b[0] = '{1'b1, 2'd2, 4'hF, 4'hF};
        b2b[1] = '{1'b1, 2'd0, 4'hA, 4'hA};
        b2b[2] = '{1'b0, 2'd2, 4'h0, 4'hF};
        b2b[3] = '{1'b0, 2'd0, 4'h0, 4'hA};
        if (VERIFY) exp_q = '{4'hF, 4'hA, 4'hF, 4'hA};
        else        exp_q = '{4'hF, 4'hA};
        idx = 0;
        cyc = 0;
        cmd_valid = 1'b1;
        cmd_write = b2b[0].w;
        cmd_addr  = b2b[0].a;
        cmd_data  = b2b[0].d;
        while (idx < 4 && cyc < 40) begin
            acc = cmd_ready;
            step();
            cyc++;
            if (rsp_valid) rsp_q.push_back(rsp_data);
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 4) begin
                    cmd_write = b2b[idx].w;
                    cmd_addr  = b2b[idx].a;
                    cmd_data  = b2b[idx].d;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        check("b2b_all_accepted", idx, 4);
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid) rsp_q.push_back(rsp_data);
        end
        check("b2b_gap_w_w", acc_cyc[1] - acc_cyc[0], VERIFY ? 4 : 2);
        check("b2b_gap_w_r", acc_cyc[2] - acc_cyc[1], VERIFY ? 4 : 2);
        check("b2b_gap_r_r", acc_cyc[3] - acc_cyc[2], 3);
        check("b2b_rsp_count", rsp_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++) begin
            check($sformatf("b2b_rsp%0d", i), rsp_q[i], exp_q[i]);
        end
        ref_mem[2] = 4'hF;
        ref_mem[0] = 4'hA;

        // Reset during CAPTURE drops the read.
        wait_ready("midrst");
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd3;
        step();
        cmd_valid = 1'b0;
        step();
        check("midrst_capture_re", rf_read_en, 1);
        rst = 1'b1;
        step();
        check("midrst_rsp", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_re", rf_read_en, 0);
        check("midrst_ready", cmd_ready, 0);
        check("midrst_radd", rf_read_add, 0);
        check("midrst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        step();
        check("midrst_rsp_after", rsp_valid, 0);
        check("midrst_ready_after", cmd_ready, 1);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            expect_cmd($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_d);
        end

`ifdef REGFILE_CTRL_VERIFY_EN
        begin
            int rdy_lat, rsp_lat;
            logic [3:0] rd;
            logic re;
            fault_en = 1'b1;
            run_cmd(1'b1, 2'd1, 4'b0101, rdy_lat, rsp_lat, rd, re);
            fault_en = 1'b0;
            check("vfault_rsp_lat", rsp_lat, 3);
            check("vfault_data", rd, 4'b0100);
            check("vfault_err", re, 1);
            check("vfault_err_count", err_count, 1);
            ref_mem[1] = 4'b0100;
            run_cmd(1'b1, 2'd0, 4'b1010, rdy_lat, rsp_lat, rd, re);
            check("vgood_rsp_lat", rsp_lat, 3);
            check("vgood_data", rd, 4'b1010);
            check("vgood_err", re, 0);
            check("vgood_err_count", err_count, 1);
            ref_mem[0] = 4'b1010;
        end
`endif

        // Randomized commands against the memory-level model.
        for (int i = 0; i < 40; i++) begin
            logic       w;
            logic [1:0] a;
            logic [3:0] d;
            w = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 3));
            d = 4'($urandom_range(0, 15));
            expect_cmd($sformatf("rnd%0d", i), w, a, d, w ? d : ref_mem[a]);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        step();
        check("enables_exclusive", both_en_cycles, 0);
        check("rsp_single_cycle", rsp_stretch, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
